tpu_result_drain: RTL and testbench

- Drain engine on the far side of the core's output-buffer read port.
- On a command, reads a contiguous range of result rows from the output buffer and streams each row as one AXI4-Stream beat to the DMA/host fabric.
- Drives the buffer's read address/enable and consumes its 1-cycle-latency read data, so the core's result path needs no external sequencing.
- Handles stream backpressure with a credit-limited 2-entry FIFO, so no read data is ever dropped.

---
 rtl/tpu_pkg.sv | 18 +
 rtl/tpu_drain_fifo.sv | 55 +++++
 rtl/tpu_result_drain.sv | 173 +++++++++++++++++
 tb/tb_tpu_result_drain.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared types and constants for the result-drain path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tpu_pkg;

    // Lane width this package's derived constants assume.
    localparam int DATA_WIDTH_ACCUM = 32;
    // tkeep bits covering one accumulator lane.
    localparam int KEEP_PER_LANE    = DATA_WIDTH_ACCUM / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } drain_state_e;

endpackage

// File: rtl/tpu_drain_fifo.sv
// Two-entry return-data FIFO carrying one result row plus its tlast flag.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none internally; the producer's credit check keeps it from overflowing.
module tpu_drain_fifo #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] head_dat,
    output logic [1:0]    cnt,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    cnt_q;

    // Storage, pointers and occupancy; push and pop in one cycle leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_dat;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign cnt      = cnt_q;
    assign full     = (cnt_q == 2'd2);
    assign empty    = (cnt_q == 2'd0);

    // The consumer only pops when the head is valid.
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/tpu_result_drain.sv
// Reads a contiguous row range from the output buffer and streams one AXI4-Stream beat per row.
// Latency: start in T -> first read in T+1 -> first beat valid in T+3; done the cycle after the last handshake.
// Backpressure: reads are credit-limited so buffered + in-flight rows never exceed the 2-entry FIFO.
module tpu_result_drain #(
    parameter int SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int DATA_WIDTH_ACCUM     = 32,
    parameter int ADDR_WIDTH           = 10,
    parameter int FIFO_DEPTH           = 2
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           cmd_start,
    input  logic [ADDR_WIDTH-1:0]                          cmd_base_addr,
    input  logic [ADDR_WIDTH:0]                            cmd_num_rows,
    input  logic [SYSTOLIC_ARRAY_WIDTH-1:0]                cmd_col_mask,
    output logic                                           busy,
    output logic                                           done,
    output logic [ADDR_WIDTH-1:0]                          ob_rd_addr,
    output logic                                           ob_rd_en,
    input  logic [DATA_WIDTH_ACCUM-1:0]                    ob_rd_data [SYSTOLIC_ARRAY_WIDTH],
    output logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_ACCUM-1:0]   m_axis_tdata,
    output logic [SYSTOLIC_ARRAY_WIDTH*DATA_WIDTH_ACCUM/8-1:0] m_axis_tkeep,
    output logic                                           m_axis_tvalid,
    input  logic                                           m_axis_tready,
    output logic                                           m_axis_tlast
);

    import tpu_pkg::*;

    localparam int W        = SYSTOLIC_ARRAY_WIDTH;
    localparam int ROW_BITS = W * DATA_WIDTH_ACCUM;
    localparam int CNT_W    = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef struct packed {
        logic [ROW_BITS-1:0] dat;
        logic                last;
    } beat_t;

    drain_state_e          state_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [CNT_W-1:0]      num_rows_q;
    logic [CNT_W-1:0]      issued_cnt_q;
    logic [CNT_W-1:0]      sent_cnt_q;
    logic [W-1:0]          col_mask_q;
    logic                  inflight_q;
    logic                  inflight_last_q;

    logic [ROW_BITS-1:0]   rd_row;
    beat_t                 push_beat;
    beat_t                 head_beat;
    logic [1:0]            fifo_cnt;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;
    logic                  rd_fire;
    logic                  issue_last;
    logic [2:0]            credit_used;
    logic [2:0]            credit_lim;

    // Flatten the buffer's per-lane read data into one row, lane i at [i*DW +: DW].
    always_comb begin
        rd_row = '0;
        for (int i = 0; i < W; i++) begin
            rd_row[i*DATA_WIDTH_ACCUM +: DATA_WIDTH_ACCUM] = ob_rd_data[i];
        end
    end

    assign pop         = m_axis_tvalid && m_axis_tready;
    // A row popped this cycle frees its slot for a read issued this cycle.
    assign credit_used = 3'(fifo_cnt) + 3'(inflight_q);
    assign credit_lim  = 3'(FIFO_DEPTH) + 3'(pop);
    assign rd_fire     = (state_q == RUN) && (issued_cnt_q < num_rows_q) && (credit_used < credit_lim);
    assign issue_last  = (issued_cnt_q == num_rows_q - CNT_ONE);

    assign ob_rd_en    = rd_fire;
    // Address wraps modulo the buffer size.
    assign ob_rd_addr  = base_q + issued_cnt_q[ADDR_WIDTH-1:0];

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);

    // Command sequencing, latched command fields and issue/send counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            base_q       <= '0;
            num_rows_q   <= '0;
            col_mask_q   <= '0;
            issued_cnt_q <= '0;
            sent_cnt_q   <= '0;
        end else begin
            if (rd_fire) begin
                issued_cnt_q <= issued_cnt_q + CNT_ONE;
            end
            if (pop) begin
                sent_cnt_q <= sent_cnt_q + CNT_ONE;
            end
            case (state_q)
                IDLE: begin
                    if (cmd_start) begin
                        base_q       <= cmd_base_addr;
                        num_rows_q   <= cmd_num_rows;
                        col_mask_q   <= cmd_col_mask;
                        issued_cnt_q <= '0;
                        sent_cnt_q   <= '0;
                        state_q      <= (cmd_num_rows == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (rd_fire && (issued_cnt_q + CNT_ONE == num_rows_q)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && (sent_cnt_q + CNT_ONE == num_rows_q)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Track the read issued last cycle so its data is captured when the buffer returns it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= rd_fire;
            inflight_last_q <= rd_fire && issue_last;
        end
    end

    assign push_beat.dat  = rd_row;
    assign push_beat.last = inflight_last_q;

    tpu_drain_fifo #(
        .DW ($bits(beat_t))
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight_q),
        .push_dat (push_beat),
        .pop      (pop),
        .head_dat (head_beat),
        .cnt      (fifo_cnt),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = head_beat.dat;
    assign m_axis_tlast  = head_beat.last && !fifo_empty;

    // Every byte of a lane follows that lane's latched column-mask bit.
    always_comb begin
        m_axis_tkeep = '0;
        for (int i = 0; i < W; i++) begin
            m_axis_tkeep[i*KEEP_PER_LANE +: KEEP_PER_LANE] = {KEEP_PER_LANE{col_mask_q[i]}};
        end
    end

    // Returning data is pushed unconditionally, so the credit rule must keep the FIFO from being full.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(inflight_q && fifo_full));

endmodule

// File: tb/tb_tpu_result_drain.sv
module tb_tpu_result_drain;

    localparam int W     = 16;
    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int NROWS = 1 << AW;

    typedef struct {
        logic [W*DW-1:0]   dat;
        logic [W*DW/8-1:0] keep;
        logic              last;
    } beat_t;

    typedef struct {
        logic [AW-1:0] base;
        int            n;
        logic [W-1:0]  mask;
        int            rdy;
        int            exp_beats;
        int            exp_reads;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_start;
    logic [AW-1:0]     cmd_base_addr;
    logic [AW:0]       cmd_num_rows;
    logic [W-1:0]      cmd_col_mask;
    logic              busy;
    logic              done;
    logic [AW-1:0]     ob_rd_addr;
    logic              ob_rd_en;
    logic [DW-1:0]     rd_data [W];
    logic [W*DW-1:0]   m_axis_tdata;
    logic [W*DW/8-1:0] m_axis_tkeep;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;

    logic [DW-1:0]     mem [NROWS][W];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int rdy_phase = 0;
    int rd_cnt = 0, pop_cnt = 0, done_cnt = 0, busy_cyc = 0;
    int first_en = -1, first_vld = -1, last_pop = -1, done_cyc = -1, t_cmd = 0;
    bit prev_stall = 0;
    beat_t prev_beat;
    beat_t exp_q[$];
    int    exp_addr[$];
    vec_t  vecs[8];

    always #5 clk = ~clk;

    tpu_result_drain dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_start     (cmd_start),
        .cmd_base_addr (cmd_base_addr),
        .cmd_num_rows  (cmd_num_rows),
        .cmd_col_mask  (cmd_col_mask),
        .busy          (busy),
        .done          (done),
        .ob_rd_addr    (ob_rd_addr),
        .ob_rd_en      (ob_rd_en),
        .ob_rd_data    (rd_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    // Output buffer: one-cycle read latency.
    always @(posedge clk) begin
        if (ob_rd_en) begin
            for (int l = 0; l < W; l++) rd_data[l] <= mem[ob_rd_addr][l];
        end
    end

    task automatic check(input bit ok, input string name, input logic [W*DW-1:0] act, input logic [W*DW-1:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic beat_t make_beat(input int addr, input logic [W-1:0] m, input bit last);
        beat_t b;
        for (int l = 0; l < W; l++) begin
            b.dat[l*DW +: DW] = mem[addr][l];
            b.keep[l*4 +: 4]  = {4{m[l]}};
        end
        b.last = last;
        return b;
    endfunction

    // Downstream ready patterns: always, 1-0-0 repeating, random.
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: m_axis_tready = 1'b1;
                1: begin m_axis_tready = (rdy_phase % 3 == 0); rdy_phase++; end
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor / scoreboard, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cyc++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (ob_rd_en) begin
                rd_cnt++;
                if (first_en < 0) first_en = cyc;
                if (exp_addr.size() == 0) check(1'b0, "rd_unexpected", ob_rd_addr, 0);
                else begin
                    int a;
                    a = exp_addr.pop_front();
                    check(int'(ob_rd_addr) == a, "rd_addr", ob_rd_addr, a);
                end
            end
            if (prev_stall) begin
                check(m_axis_tvalid && m_axis_tdata == prev_beat.dat && m_axis_tkeep == prev_beat.keep
                      && m_axis_tlast == prev_beat.last, "stall_hold", m_axis_tdata, prev_beat.dat);
            end
            if (m_axis_tvalid && first_vld < 0) first_vld = cyc;
            if (m_axis_tvalid && m_axis_tready) begin
                pop_cnt++;
                last_pop = cyc;
                if (exp_q.size() == 0) check(1'b0, "beat_unexpected", m_axis_tdata, 0);
                else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check(m_axis_tdata == e.dat, "beat_data", m_axis_tdata, e.dat);
                    check(m_axis_tkeep == e.keep, "beat_keep", m_axis_tkeep, e.keep);
                    check(m_axis_tlast == e.last, "beat_last", m_axis_tlast, e.last);
                end
            end
            if (ob_rd_en || (m_axis_tvalid && m_axis_tready))
                check((rd_cnt - pop_cnt) <= 2, "outstanding", rd_cnt - pop_cnt, 2);
            prev_stall     = m_axis_tvalid && !m_axis_tready;
            prev_beat.dat  = m_axis_tdata;
            prev_beat.keep = m_axis_tkeep;
            prev_beat.last = m_axis_tlast;
        end
    end

    task automatic issue_cmd(input int b, input int n, input logic [W-1:0] m, input bit accept);
        @(posedge clk); #1;
        if (accept) begin
            rd_cnt = 0; pop_cnt = 0; done_cnt = 0; busy_cyc = 0;
            first_en = -1; first_vld = -1; last_pop = -1; done_cyc = -1;
            for (int i = 0; i < n; i++) begin
                exp_addr.push_back((b + i) % NROWS);
                exp_q.push_back(make_beat((b + i) % NROWS, m, i == n - 1));
            end
            t_cmd = cyc + 1;
        end
        cmd_start     = 1'b1;
        cmd_base_addr = AW'(b);
        cmd_num_rows  = (AW+1)'(n);
        cmd_col_mask  = m;
        @(posedge clk); #1;
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check(done_cnt != 0, "done_timeout", done_cnt, 1);
        repeat (2) begin @(negedge clk); #1; end
        check(exp_q.size() == 0, "beats_left", exp_q.size(), 0);
        check(exp_addr.size() == 0, "reads_left", exp_addr.size(), 0);
    endtask

    initial begin
        rst = 1'b0; cmd_start = 1'b0; cmd_base_addr = '0; cmd_num_rows = '0; cmd_col_mask = '0;
        for (int r = 0; r < NROWS; r++)
            for (int l = 0; l < W; l++)
                mem[r][l] = (r < 4) ? DW'(100 * r + l) : $urandom;
        for (int l = 0; l < W; l++) rd_data[l] = '0;

        // Reset state, checked between edges while reset is held.
        #1 rst = 1'b1;
        #1;
        check(busy == 1'b0, "rst_busy", busy, 0);
        check(done == 1'b0, "rst_done", done, 0);
        check(ob_rd_en == 1'b0, "rst_rd_en", ob_rd_en, 0);
        check(ob_rd_addr == '0, "rst_rd_addr", ob_rd_addr, 0);
        check(m_axis_tvalid == 1'b0, "rst_tvalid", m_axis_tvalid, 0);
        check(m_axis_tlast == 1'b0, "rst_tlast", m_axis_tlast, 0);
        check(m_axis_tdata == '0, "rst_tdata", m_axis_tdata, 0);
        check(m_axis_tkeep == '0, "rst_tkeep", m_axis_tkeep, 0);
        #20 rst = 1'b0;

        // Rows 0..3 with tready high: exact latency profile.
        rdy_mode = 0;
        issue_cmd(0, 4, 16'hFFFF, 1);
        wait_done(60);
        check(first_en == t_cmd + 1, "lat_first_rd", first_en, t_cmd + 1);
        check(rd_cnt == 4, "lat_rd_cnt", rd_cnt, 4);
        check(first_vld == t_cmd + 3, "lat_first_vld", first_vld, t_cmd + 3);
        check(last_pop == t_cmd + 6, "lat_last_beat", last_pop, t_cmd + 6);
        check(done_cyc == t_cmd + 7, "lat_done", done_cyc, t_cmd + 7);
        check(pop_cnt == 4, "lat_beats", pop_cnt, 4);

        // Zero rows: no reads, no beats, one busy cycle, done at T+1.
        issue_cmd(0, 0, 16'hFFFF, 1);
        wait_done(20);
        check(rd_cnt == 0, "zero_rd", rd_cnt, 0);
        check(pop_cnt == 0, "zero_beats", pop_cnt, 0);
        check(busy_cyc == 1, "zero_busy", busy_cyc, 1);
        check(done_cyc == t_cmd + 1, "zero_done", done_cyc, t_cmd + 1);

        // Half mask plus a start while busy that must be ignored.
        issue_cmd(0, 4, 16'h00FF, 1);
        issue_cmd(5, 3, 16'hFFFF, 0);
        wait_done(60);
        repeat (4) @(negedge clk);
        #1;
        check(pop_cnt == 4, "ignored_start_beats", pop_cnt, 4);
        check(done_cnt == 1, "ignored_start_done", done_cnt, 1);

        // Table-driven commands.
        vecs[0] = '{base: 0,    n: 4,    mask: 16'hFFFF, rdy: 1, exp_beats: 4,    exp_reads: 4};
        vecs[1] = '{base: 1022, n: 4,    mask: 16'hFFFF, rdy: 0, exp_beats: 4,    exp_reads: 4};
        vecs[2] = '{base: 1022, n: 4,    mask: 16'hA5A5, rdy: 2, exp_beats: 4,    exp_reads: 4};
        vecs[3] = '{base: 1023, n: 1,    mask: 16'h0001, rdy: 0, exp_beats: 1,    exp_reads: 1};
        vecs[4] = '{base: 500,  n: 9,    mask: 16'h00FF, rdy: 1, exp_beats: 9,    exp_reads: 9};
        vecs[5] = '{base: 3,    n: 0,    mask: 16'hFFFF, rdy: 2, exp_beats: 0,    exp_reads: 0};
        vecs[6] = '{base: 17,   n: 1024, mask: 16'hFFFF, rdy: 0, exp_beats: 1024, exp_reads: 1024};
        vecs[7] = '{base: 1000, n: 40,   mask: 16'hF00F, rdy: 2, exp_beats: 40,   exp_reads: 40};
        for (int v = 0; v < 8; v++) begin
            rdy_mode = vecs[v].rdy;
            rdy_phase = 0;
            issue_cmd(vecs[v].base, vecs[v].n, vecs[v].mask, 1);
            wait_done(40 + 8 * vecs[v].n);
            check(pop_cnt == vecs[v].exp_beats, "vec_beats", pop_cnt, vecs[v].exp_beats);
            check(rd_cnt == vecs[v].exp_reads, "vec_reads", rd_cnt, vecs[v].exp_reads);
        end

        // Randomized commands under random backpressure.
        rdy_mode = 2;
        for (int i = 0; i < 25; i++) begin
            int n;
            n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
            issue_cmd($urandom_range(0, NROWS - 1), n, W'($urandom), 1);
            wait_done(40 + 8 * n);
            check(pop_cnt == n, "rand_beats", pop_cnt, n);
        end

        // Asynchronous reset with two beats still pending.
        rdy_mode = 0;
        issue_cmd(0, 4, 16'hFFFF, 1);
        begin
            int k = 0;
            while (pop_cnt < 2 && k < 30) begin @(negedge clk); #1; k++; end
            check(pop_cnt == 2, "mid_rst_setup", pop_cnt, 2);
        end
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check(m_axis_tvalid == 1'b0, "mid_rst_tvalid", m_axis_tvalid, 0);
        check(busy == 1'b0, "mid_rst_busy", busy, 0);
        check(ob_rd_en == 1'b0, "mid_rst_rd_en", ob_rd_en, 0);
        exp_q.delete();
        exp_addr.delete();
        prev_stall = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check(pop_cnt == 2, "mid_rst_no_beats", pop_cnt, 2);
        issue_cmd(7, 2, 16'hF0F0, 1);
        wait_done(40);
        check(pop_cnt == 2, "post_rst_beats", pop_cnt, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
